ram_1w_1rs_fifo_ctrl: RTL and testbench

//   Single-clock FIFO controller that drives the write and read ports of an external
//   Ram_1w_1rs instance; it is the initiator of that RAM's port protocol.
//   - Upstream side: valid/ready stream written into the RAM.
//   - Downstream side: first-word-fall-through valid/ready stream that hides the
//     RAM's 1-cycle synchronous read latency behind a 2-entry output buffer.

---
 rtl/ram_1w_1rs_fifo_ctrl_if.sv | 21 ++
 rtl/ram_1w_1rs_fifo_ctrl.sv | 106 ++++++++++
 tb/tb_ram_1w_1rs_fifo_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_1w_1rs_fifo_ctrl_if.sv
// Valid/ready stream bundle for the FIFO controller.
// master drives valid/data, slave drives ready.
interface ram_1w_1rs_fifo_ctrl_if #(
  parameter int unsigned DW = 32
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/ram_1w_1rs_fifo_ctrl.sv
// RAM-backed FIFO controller: writes s stream into an external 1w/1r RAM,
// presents m stream via 2-entry output buffer. Ports: clk, resetn, s, m, level, ram_*.
module ram_1w_1rs_fifo_ctrl #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  ram_1w_1rs_fifo_ctrl_if.slave     s,
  ram_1w_1rs_fifo_ctrl_if.master    m,
  output logic [AW+1:0]             level,
  output logic                      ram_wr_en,
  output logic                      ram_wr_mask,
  output logic [AW-1:0]             ram_wr_addr,
  output logic [DW-1:0]             ram_wr_data,
  output logic                      ram_rd_en,
  output logic [AW-1:0]             ram_rd_addr,
  input  logic [DW-1:0]             ram_rd_data
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic [AW:0]   ram_cnt;
  logic          inflight;
  logic [1:0]    obuf_cnt;
  logic [1:0]    obuf_cnt_nxt;
  logic [DW-1:0] head;
  logic [DW-1:0] tail;
  logic          wr;
  logic          rd;
  logic          push;
  logic          pop;

  // ram_cnt sees only earlier writes, so a read never
  // targets the slot being written this cycle.
  assign ram_cnt = wptr - rptr;
  assign s.ready = (ram_cnt != (AW+1)'(DEPTH));
  assign wr      = s.valid & s.ready;

  assign m.valid = (obuf_cnt != 2'd0);
  assign m.data  = head;
  assign pop     = m.valid & m.ready;
  assign push    = inflight;

  // Room must exist for the word in flight plus
  // the one issued now, after this cycle's pop.
  assign obuf_cnt_nxt = obuf_cnt - {1'b0, pop};
  assign rd = (ram_cnt != '0) &
              (({1'b0, obuf_cnt_nxt} +
                {2'b00, inflight}) < 3'd2);

  assign ram_wr_en   = wr;
  assign ram_wr_mask = 1'b1;
  assign ram_wr_addr = wptr[AW-1:0];
  assign ram_wr_data = s.data;
  assign ram_rd_en   = rd;
  assign ram_rd_addr = rptr[AW-1:0];

  assign level = (AW+2)'(ram_cnt) +
                 (AW+2)'(inflight) +
                 (AW+2)'(obuf_cnt);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr     <= '0;
      rptr     <= '0;
      inflight <= 1'b0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      inflight <= rd;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      obuf_cnt <= 2'd0;
      head     <= '0;
      tail     <= '0;
    end else begin
      unique case (1'b1)
        push & ~pop: begin
          if (obuf_cnt == 2'd0) head <= ram_rd_data;
          else                  tail <= ram_rd_data;
          obuf_cnt <= obuf_cnt + 2'd1;
        end
        pop & ~push: begin
          head     <= tail;
          obuf_cnt <= obuf_cnt - 2'd1;
        end
        push & pop: begin
          if (obuf_cnt == 2'd1) begin
            head <= ram_rd_data;
          end else begin
            head <= tail;
            tail <= ram_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_1w_1rs_fifo_ctrl.sv
// Bench for ram_1w_1rs_fifo_ctrl: RAM model plus queue reference.
// Directed and random traffic; level and data checked every cycle.
module tb_ram_1w_1rs_fifo_ctrl;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic [AW+1:0] level;
  logic          ram_wr_en;
  logic          ram_wr_mask;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;

  ram_1w_1rs_fifo_ctrl_if #(.DW(DW)) sif ();
  ram_1w_1rs_fifo_ctrl_if #(.DW(DW)) mif ();

  ram_1w_1rs_fifo_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .s           (sif),
    .m           (mif),
    .level       (level),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_mask (ram_wr_mask),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [2**AW];

  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
  end

  int            checks = 0;
  int            failures = 0;
  int            cyc_n = 0;
  bit            fired;
  bit            popped;
  logic [DW-1:0] q [$];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes, advance the queue model, check level.
  task automatic cyc();
    logic [DW-1:0] d;
    #1;
    fired  = sif.valid & sif.ready;
    popped = mif.valid & mif.ready;
    d      = sif.data;
    if (ram_wr_en & ram_rd_en)
      chk("rw_collide", 64'(ram_wr_addr == ram_rd_addr), 64'd0);
    if (fired) begin
      chk("wr_en", 64'(ram_wr_en), 64'd1);
      chk("wr_mask", 64'(ram_wr_mask), 64'd1);
      chk("wr_data", 64'(ram_wr_data), 64'(d));
    end
    if (popped) begin
      if (q.size() == 0) chk("pop_when_empty", 64'(popped), 64'd0);
      else               chk("m_data", 64'(mif.data), 64'(q[0]));
    end
    @(posedge clk);
    #1;
    if (popped && q.size() != 0) void'(q.pop_front());
    if (fired) q.push_back(d);
    cyc_n++;
    chk("level", 64'(level), 64'(q.size()));
    @(negedge clk);
  endtask

  task automatic drain();
    sif.valid = 1'b0;
    mif.ready = 1'b1;
    for (int i = 0; i < 300 && q.size() != 0; i++) cyc();
    cyc();
    cyc();
    chk("drain_level", 64'(level), 64'd0);
    chk("drain_mvalid", 64'(mif.valid), 64'd0);
    mif.ready = 1'b0;
  endtask

  // Continuous stream of n words with m_ready held high.
  task automatic stream(input int n, input string tag);
    int sent = 0;
    int npop = 0;
    int first = -1;
    int last = 0;
    int bubbles = 0;
    mif.ready = 1'b1;
    for (int i = 0; i < 400 && (sent < n || q.size() != 0); i++) begin
      sif.valid = (sent < n);
      sif.data  = 32'(sent) ^ 32'h5a00_0000;
      cyc();
      if (fired) sent++;
      if (popped) begin
        if (first < 0) first = cyc_n;
        else if (cyc_n != last + 1) bubbles++;
        last = cyc_n;
        npop++;
      end
    end
    sif.valid = 1'b0;
    chk({tag, "_pops"}, 64'(npop), 64'(n));
    chk({tag, "_span"}, 64'(last - first), 64'(n - 1));
    chk({tag, "_bubbles"}, 64'(bubbles), 64'd0);
  endtask

  initial begin
    int acc;
    int sent;
    resetn    = 1'b0;
    sif.valid = 1'b0;
    sif.data  = '0;
    mif.ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mvalid", 64'(mif.valid), 64'd0);
    chk("rst_sready", 64'(sif.ready), 64'd1);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_wren", 64'(ram_wr_en), 64'd0);
    chk("rst_rden", 64'(ram_rd_en), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // single word latency
    sif.valid = 1'b1;
    sif.data  = 32'ha5a5_0001;
    cyc();
    sif.valid = 1'b0;
    chk("lat_t1", 64'(mif.valid), 64'd0);
    cyc();
    chk("lat_t2", 64'(mif.valid), 64'd0);
    cyc();
    chk("lat_t3", 64'(mif.valid), 64'd1);
    chk("lat_data", 64'(mif.data), 64'h a5a5_0001);
    drain();

    // 100-word stream
    stream(100, "s100");
    drain();

    // fill with m_ready low
    mif.ready = 1'b0;
    sif.valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      sif.data = $urandom;
      cyc();
      if (fired) acc++;
    end
    sif.valid = 1'b0;
    chk("full_acc", 64'(acc), 64'd34);
    chk("full_level", 64'(level), 64'd34);
    chk("full_sready", 64'(sif.ready), 64'd0);
    mif.ready = 1'b1;
    cyc();
    mif.ready = 1'b0;
    chk("pop1_sready", 64'(sif.ready), 64'd1);
    chk("pop1_level", 64'(level), 64'd33);
    drain();

    // pointer wrap with random traffic
    for (int r = 0; r < 3; r++) begin
      sent = 0;
      for (int i = 0; i < 2000 && sent < 32; i++) begin
        sif.valid = ($urandom_range(0, 9) < 7);
        sif.data  = $urandom;
        mif.ready = ($urandom_range(0, 9) < 3);
        cyc();
        if (fired) sent++;
      end
      sif.valid = 1'b0;
      chk("wrap_sent", 64'(sent), 64'd32);
      for (int i = 0; i < 2000 && q.size() != 0; i++) begin
        mif.ready = ($urandom_range(0, 1) == 1);
        cyc();
      end
      chk("wrap_level", 64'(level), 64'd0);
    end
    drain();

    // reset mid-operation with a read in flight
    mif.ready = 1'b0;
    sif.valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sif.data = 32'hdead_0000 + 32'(i);
      cyc();
    end
    sif.valid = 1'b0;
    repeat (3) cyc();
    mif.ready = 1'b1;
    cyc();
    mif.ready = 1'b0;
    chk("pre_rst_rd", 64'(level), 64'd9);
    resetn = 1'b0;
    #1;
    chk("mrst_mvalid", 64'(mif.valid), 64'd0);
    chk("mrst_level", 64'(level), 64'd0);
    chk("mrst_sready", 64'(sif.ready), 64'd1);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    sif.valid = 1'b1;
    sif.data  = 32'h0000_1234;
    cyc();
    sif.valid = 1'b0;
    cyc();
    cyc();
    chk("post_rst_mvalid", 64'(mif.valid), 64'd1);
    chk("post_rst_data", 64'(mif.data), 64'h1234);
    drain();

    // steady push+pop through a one-entry buffer
    stream(20, "s20");
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
